// File: rtl/audio_sample_fifo.sv
// Multi-channel audio sample FIFO in the audio-clock domain.
// Buffers CHANNELS-wide frames between the CDC stage and the serialiser,
// reports fill level and raises sticky overflow/underflow flags.
module audio_sample_fifo #(
  parameter int DATA_W   = 24,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 8,
  parameter int UF_HOLD  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         play_in,
  input  logic                         tick_in,
  input  logic [CHANNELS*DATA_W-1:0]   audio_in,
  input  logic                         req_in,
  input  logic                         clr_in,
  output logic [CHANNELS*DATA_W-1:0]   audio_out,
  output logic                         tick_out,
  output logic [$clog2(DEPTH):0]       level_out,
  output logic                         full_out,
  output logic                         empty_out,
  output logic                         ovf_out,
  output logic                         udf_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int FW = CHANNELS * DATA_W;

  logic [FW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic do_pop;
  logic do_push;
  logic ovf_evt;
  logic udf_evt;

  // Status decode from the registered pointers
  always_comb begin
    level_out = wr_ptr - rd_ptr;
    empty_out = (wr_ptr == rd_ptr);
    full_out  = (level_out == PW'(DEPTH));
  end

  // Event decode; a write at full survives only when a pop frees the slot in the same cycle
  always_comb begin
    do_pop  = play_in && req_in && !empty_out;
    do_push = play_in && tick_in && (!full_out || do_pop);
    ovf_evt = play_in && tick_in && !do_push;
    udf_evt = play_in && req_in && empty_out;
  end

  // Frame storage; no reset needed since pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= audio_in;
    end
  end

  // Pointers, output frame, strobe and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      audio_out <= '0;
      tick_out  <= 1'b0;
      ovf_out   <= 1'b0;
      udf_out   <= 1'b0;
    end else if (!play_in) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      audio_out <= '0;
      tick_out  <= 1'b0;
      ovf_out   <= 1'b0;
      udf_out   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        audio_out <= mem[rd_ptr[AW-1:0]];
      end else if (udf_evt && (UF_HOLD == 0)) begin
        audio_out <= '0;
      end
      tick_out <= req_in;
      // A new event takes priority over a coincident clear
      if (ovf_evt) begin
        ovf_out <= 1'b1;
      end else if (clr_in) begin
        ovf_out <= 1'b0;
      end
      if (udf_evt) begin
        udf_out <= 1'b1;
      end else if (clr_in) begin
        udf_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed self-checking bench for audio_sample_fifo (zero-fill and hold-last variants).
module tb_audio_sample_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        play_in, tick_in, req_in, clr_in;
  logic [47:0] audio_in;
  logic [47:0] audio_out, audio_out_h;
  logic        tick_out, tick_out_h;
  logic [3:0]  level_out, level_out_h;
  logic        full_out, full_out_h, empty_out, empty_out_h;
  logic        ovf_out, ovf_out_h, udf_out, udf_out_h;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  audio_sample_fifo #(.DATA_W(24), .CHANNELS(2), .DEPTH(8), .UF_HOLD(0)) dut (
    .clk(clk), .rst_n(rst_n), .play_in(play_in), .tick_in(tick_in),
    .audio_in(audio_in), .req_in(req_in), .clr_in(clr_in),
    .audio_out(audio_out), .tick_out(tick_out), .level_out(level_out),
    .full_out(full_out), .empty_out(empty_out), .ovf_out(ovf_out), .udf_out(udf_out)
  );

  audio_sample_fifo #(.DATA_W(24), .CHANNELS(2), .DEPTH(8), .UF_HOLD(1)) dut_h (
    .clk(clk), .rst_n(rst_n), .play_in(play_in), .tick_in(tick_in),
    .audio_in(audio_in), .req_in(req_in), .clr_in(clr_in),
    .audio_out(audio_out_h), .tick_out(tick_out_h), .level_out(level_out_h),
    .full_out(full_out_h), .empty_out(empty_out_h), .ovf_out(ovf_out_h), .udf_out(udf_out_h)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] frame(input logic [23:0] ch1, input logic [23:0] ch0);
    return {ch1, ch0};
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill8(input logic [23:0] base);
    tick_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      audio_in = frame(base + 24'(2*i + 1), base + 24'(2*i));
      step();
    end
    tick_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; play_in = 1'b0; tick_in = 1'b0; req_in = 1'b0; clr_in = 1'b0;
    audio_in = '0;
    step(); step();

    // 1: reset state
    check("rst_audio", audio_out, 0);
    check("rst_level", level_out, 0);
    check("rst_empty", empty_out, 1);
    check("rst_full",  full_out, 0);
    check("rst_ovf",   ovf_out, 0);
    check("rst_udf",   udf_out, 0);
    check("rst_tick",  tick_out, 0);
    check("rst_audio_h", audio_out_h, 0);

    rst_n = 1'b1; play_in = 1'b1;
    step();

    // 2: eight frames in, eight out in order
    tick_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      audio_in = frame(24'(2*i + 2), 24'(2*i + 1));
      step();
    end
    tick_in = 1'b0;
    check("t2_level8", level_out, 8);
    check("t2_full", full_out, 1);
    req_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t2_data", audio_out, frame(24'(2*i + 2), 24'(2*i + 1)));
      check("t2_tick", tick_out, 1);
      check("t2_level", level_out, 4'(7 - i));
    end
    req_in = 1'b0;
    step();
    check("t2_tick_off", tick_out, 0);
    check("t2_empty", empty_out, 1);
    check("t2_udf", udf_out, 0);

    // 3: overflow drop, then simultaneous tick+req at full
    fill8(24'h000100);
    tick_in = 1'b1; audio_in = frame(24'hDEAD01, 24'hDEAD00);
    step();
    tick_in = 1'b0;
    check("t3_ovf", ovf_out, 1);
    check("t3_level_drop", level_out, 8);
    tick_in = 1'b1; req_in = 1'b1; audio_in = frame(24'h000077, 24'h000066);
    step();
    tick_in = 1'b0;
    check("t3_level_both", level_out, 8);
    check("t3_head", audio_out, frame(24'h000101, 24'h000100));
    for (int i = 1; i < 8; i++) begin
      step();
      check("t3_drain", audio_out, frame(24'h000100 + 24'(2*i + 1), 24'h000100 + 24'(2*i)));
    end
    step();
    req_in = 1'b0;
    check("t3_kept", audio_out, frame(24'h000077, 24'h000066));
    check("t3_empty", level_out, 0);
    clr_in = 1'b1;
    step();
    clr_in = 1'b0;
    check("t3_clr", ovf_out, 0);

    // 4: underflow, zero fill versus hold-last
    tick_in = 1'b1; audio_in = frame(24'hABCDEF, 24'hABCDEF);
    step();
    tick_in = 1'b0; req_in = 1'b1;
    step();
    check("t4_pop", audio_out, frame(24'hABCDEF, 24'hABCDEF));
    check("t4_pop_h", audio_out_h, frame(24'hABCDEF, 24'hABCDEF));
    check("t4_no_udf", udf_out, 0);
    step();
    req_in = 1'b0;
    check("t4_zero", audio_out, 0);
    check("t4_hold", audio_out_h, frame(24'hABCDEF, 24'hABCDEF));
    check("t4_udf", udf_out, 1);
    check("t4_tick", tick_out, 1);
    check("t4_udf_h", udf_out_h, 1);
    clr_in = 1'b1;
    step();
    clr_in = 1'b0;
    check("t4_clr", udf_out, 0);

    // 5: empty with tick and req together: underflow, write stored
    tick_in = 1'b1; req_in = 1'b1; audio_in = frame(24'h123456, 24'h654321);
    step();
    tick_in = 1'b0;
    check("t5_udf", udf_out, 1);
    check("t5_level", level_out, 1);
    check("t5_tick", tick_out, 1);
    check("t5_zero", audio_out, 0);
    step();
    req_in = 1'b0;
    check("t5_data", audio_out, frame(24'h123456, 24'h654321));
    check("t5_level0", level_out, 0);

    // 6: flush at level 5 with ovf set; strobes ignored while idle
    fill8(24'h000200);
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    req_in = 1'b1;
    step(); step(); step();
    req_in = 1'b0;
    check("t6_level5", level_out, 5);
    check("t6_ovf", ovf_out, 1);
    play_in = 1'b0; tick_in = 1'b1; req_in = 1'b1;
    step();
    tick_in = 1'b0; req_in = 1'b0;
    check("t6_flush_level", level_out, 0);
    check("t6_flush_ovf", ovf_out, 0);
    check("t6_flush_udf", udf_out, 0);
    check("t6_flush_audio", audio_out, 0);
    check("t6_flush_tick", tick_out, 0);
    check("t6_flush_empty", empty_out, 1);
    play_in = 1'b1;
    fill8(24'h000300);
    check("t6_refill", level_out, 8);
    tick_in = 1'b1; clr_in = 1'b1;
    step();
    tick_in = 1'b0;
    check("t6_clr_vs_ovf", ovf_out, 1);
    step();
    clr_in = 1'b0;
    check("t6_clr_after", ovf_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
